// File: rtl/riscv_boot_loader.sv
// Byte-stream program loader feeding riscv_sc_top instruction memory; holds the core in reset until a checksum-verified load.
// Optional inter-byte timeout: define BOOT_LOADER_TIMEOUT_EN.
module riscv_boot_loader #(
  parameter int DW             = 32,
  parameter int MEM_SIZE_IN_KB = 1,
  parameter int NO_OF_REGS     = MEM_SIZE_IN_KB*1024/4,
  parameter int AW             = $clog2(NO_OF_REGS)+2,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [7:0]    byte_i,
  input  logic          byte_valid_i,
  output logic          byte_ready_o,
  output logic          imem_we_o,
  output logic [AW-1:0] imem_addr_o,
  output logic [DW-1:0] imem_wdata_o,
  output logic          core_rst_o,
  output logic          done_o,
  output logic          err_o,
  output logic [AW-2:0] words_loaded_o
);

  typedef enum logic [2:0] {S_LEN, S_DATA, S_WRITE, S_CHK, S_DONE, S_ERR} state_t;

  state_t        state_q, state_d;
  logic [1:0]    bcnt_q;
  logic [31:0]   cnt_q;
  logic [DW-1:0] word_q;
  logic [7:0]    chk_q;
  logic [AW-2:0] idx_q;
  logic          ready_q;
  logic          core_rst_q;
  logic          acc;
  logic [31:0]   len_full;
  logic          tmo_hit;

  assign acc      = byte_valid_i && ready_q;
  // count as it will look once the current byte is shifted in
  assign len_full = {byte_i, cnt_q[31:8]};

`ifdef BOOT_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] tmo_q;
  logic          tmo_run;

  // idle before the first header byte is legal; WRITE freezes the count
  assign tmo_run = (state_q == S_LEN && bcnt_q != 2'd0) || state_q == S_DATA || state_q == S_CHK;
  assign tmo_hit = tmo_run && !acc && (tmo_q == TW'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)      tmo_q <= '0;
    else if (acc)     tmo_q <= '0;
    else if (tmo_run) tmo_q <= tmo_q + 1'b1;
  end
`else
  logic unused_tmo;
  assign unused_tmo = ^TIMEOUT_CYCLES;
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= S_LEN;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_LEN:   if (acc && bcnt_q == 2'd3) begin
                 if (len_full > 32'(NO_OF_REGS)) state_d = S_ERR;
                 else if (len_full == '0)        state_d = S_CHK;
                 else                            state_d = S_DATA;
               end
      S_DATA:  if (acc && bcnt_q == 2'd3) state_d = S_WRITE;
      S_WRITE: state_d = (32'(idx_q) + 32'd1 == cnt_q) ? S_CHK : S_DATA;
      S_CHK:   if (acc) state_d = (byte_i == chk_q) ? S_DONE : S_ERR;
      S_DONE:  state_d = S_DONE;
      S_ERR:   state_d = S_ERR;
      default: state_d = S_ERR;
    endcase
    if (tmo_hit) state_d = S_ERR;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      bcnt_q     <= '0;
      cnt_q      <= '0;
      word_q     <= '0;
      chk_q      <= '0;
      idx_q      <= '0;
      ready_q    <= 1'b0;
      core_rst_q <= 1'b1;
    end else begin
      // 2-bit byte counter wraps to 0 after each 4-byte field
      if (acc && (state_q == S_LEN || state_q == S_DATA)) bcnt_q <= bcnt_q + 2'd1;
      if (acc && state_q == S_LEN) cnt_q <= len_full;
      if (acc && state_q == S_DATA) begin
        word_q <= {byte_i, word_q[DW-1:8]};
        chk_q  <= chk_q ^ byte_i;
      end
      if (state_q == S_WRITE) idx_q <= idx_q + 1'b1;
      ready_q    <= (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CHK);
      core_rst_q <= (state_q != S_DONE);
    end
  end

  always_comb begin
    imem_we_o = (state_q == S_WRITE);
    done_o    = (state_q == S_DONE);
    err_o     = (state_q == S_ERR);
  end

  assign byte_ready_o   = ready_q;
  assign core_rst_o     = core_rst_q;
  assign imem_addr_o    = {idx_q[AW-3:0], 2'b00};
  assign imem_wdata_o   = word_q;
  assign words_loaded_o = idx_q;

endmodule
